// File: rtl/divide_and_round_arbiter_if.sv
// Bundle of the requester, flush and divider-side signals of divide_and_round_arbiter.
// slave: the arbiter's view. master: the environment (requesters plus divider).
interface divide_and_round_arbiter_if #(
    parameter int N_REQ     = 3,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 9
);
    // Requester handshake: a sample moves on a rising edge where
    // req_valid[i] & req_ready[i]. At most one ready bit is set per cycle.
    // Results come back with a one-cycle, one-hot res_valid and no back-pressure.
    logic [N_REQ-1:0]          req_valid;
    logic [N_REQ-1:0]          req_ready;
    logic [N_REQ*IN_WIDTH-1:0] req_data;
    logic                      flush;
    logic                      flush_done;
    logic                      busy;
    logic                      dr_en;
    logic [IN_WIDTH-1:0]       dr_in;
    logic [OUT_WIDTH-1:0]      dr_out;
    logic [N_REQ-1:0]          res_valid;
    logic [OUT_WIDTH-1:0]      res_data;

    modport slave (
        input  req_valid, req_data, flush, dr_out,
        output req_ready, flush_done, busy, dr_en, dr_in, res_valid, res_data
    );

    modport master (
        output req_valid, req_data, flush, dr_out,
        input  req_ready, flush_done, busy, dr_en, dr_in, res_valid, res_data
    );
endinterface

// File: rtl/divide_and_round_arbiter.sv
// divide_and_round_arbiter: shares one divide_and_round pipeline among N_REQ
// requesters. It grants one sample per cycle and tags each sample with its
// owner. Each result returns on a shared bus with a one-hot valid. A
// flush/drain sequencer quiesces the pipeline.
// Optional macro DIVROUND_ARB_RR_EN: round-robin arbitration. When it is not
// defined, the lowest requester index always wins.
module divide_and_round_arbiter #(
    parameter int N_REQ     = 3,
    parameter int IN_WIDTH  = 12,
    parameter int OUT_WIDTH = 9,
    parameter int PIPE_LAT  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    divide_and_round_arbiter_if.slave bus,
    output logic                      o_dbg_state
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW  = $clog2(PIPE_LAT + 1);

    typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_grant_ok;
    logic                 w_found;
    logic [IDW-1:0]       w_grant_id;
    logic [N_REQ-1:0]     w_ready;
    logic                 w_accept;
    logic [IN_WIDTH-1:0]  w_dr_in;
    logic                 w_dr_en;
    logic [PIPE_LAT-1:0]  r_tag_v;
    logic [IDW-1:0]       r_tag_id [PIPE_LAT];
    logic                 w_retire;
    logic                 w_drained;
    logic [CW-1:0]        r_inflight;
    logic [N_REQ-1:0]     w_res_onehot;
    logic [N_REQ-1:0]     r_res_valid;
    logic [OUT_WIDTH-1:0] r_res_data;
    logic                 r_flush_done;
    logic                 w_busy;

`ifdef DIVROUND_ARB_RR_EN
    logic [IDW-1:0]       r_last_grant;

    // Round-robin search that starts one past the last accepted requester.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!w_found && bus.req_valid[IDW'((int'(r_last_grant) + k) % N_REQ)]) begin
                w_found    = 1'b1;
                w_grant_id = IDW'((int'(r_last_grant) + k) % N_REQ);
            end
        end
    end

    // The pointer moves only on an accept. Its reset value lets requester 0 win first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= IDW'(N_REQ - 1);
        end else if (w_accept) begin
            r_last_grant <= w_grant_id;
        end
    end
`else
    // Fixed priority: the lowest index with a valid sample wins.
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && bus.req_valid[IDW'(k)]) begin
                w_found    = 1'b1;
                w_grant_id = IDW'(k);
            end
        end
    end
`endif

    // One-hot grant. Held at 0 in reset, while draining, and in any flush cycle.
    always_comb begin
        w_ready = '0;
        if (w_grant_ok && w_found) begin
            w_ready[w_grant_id] = 1'b1;
        end
    end

    assign w_accept = |(bus.req_valid & w_ready);

    // Route the granted requester's sample to the divider. Use 0 when nothing is granted.
    always_comb begin
        w_dr_in = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_accept && (w_grant_id == IDW'(i))) begin
                w_dr_in = bus.req_data[i*IN_WIDTH +: IN_WIDTH];
            end
        end
    end

    // The divider runs whenever something is in it or entering it, so no result stalls.
    assign w_dr_en  = !rst && (w_accept || (r_inflight != '0));
    assign w_retire = w_dr_en && r_tag_v[PIPE_LAT-1];
    assign w_drained = (r_inflight == '0) && (r_tag_v == '0);

    // Tag pipeline mirrors the divider stages: {valid, owner id} per stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_v <= '0;
            for (int s = 0; s < PIPE_LAT; s++) begin
                r_tag_id[s] <= '0;
            end
        end else if (w_dr_en) begin
            r_tag_v[0]  <= w_accept;
            r_tag_id[0] <= w_grant_id;
            for (int s = 1; s < PIPE_LAT; s++) begin
                r_tag_v[s]  <= r_tag_v[s-1];
                r_tag_id[s] <= r_tag_id[s-1];
            end
        end
    end

    // Decode the owner of the retiring sample into the one-hot result valid.
    always_comb begin
        w_res_onehot = '0;
        w_res_onehot[r_tag_id[PIPE_LAT-1]] = 1'b1;
    end

    // Register each retiring result. res_valid is one cycle wide and res_data holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= '0;
            r_res_data  <= '0;
        end else begin
            r_res_valid <= w_retire ? w_res_onehot : '0;
            if (w_retire) begin
                r_res_data <= bus.dr_out;
            end
        end
    end

    // Count samples in flight. An accept and a retire in the same cycle cancel.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else if (w_accept && !w_retire) begin
            r_inflight <= r_inflight + CW'(1);
        end else if (!w_accept && w_retire) begin
            r_inflight <= r_inflight - CW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state. flush moves RUN to DRAIN. An empty pipeline returns DRAIN to RUN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (bus.flush) w_state_next = ST_DRAIN;
            ST_DRAIN: if (w_drained) w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    // FSM outputs: grant permission and busy.
    always_comb begin
        w_grant_ok = !rst && (r_state == ST_RUN) && !bus.flush;
        w_busy     = (r_inflight != '0) || (r_state == ST_DRAIN);
    end

    // Pulse flush_done on the edge that leaves DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= (r_state == ST_DRAIN) && w_drained;
        end
    end

    assign bus.req_ready  = w_ready;
    assign bus.dr_en      = w_dr_en;
    assign bus.dr_in      = w_dr_in;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_data   = r_res_data;
    assign bus.flush_done = r_flush_done;
    assign bus.busy       = w_busy;
    assign o_dbg_state    = r_state;
endmodule
